// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
// Optional build macro CDB_ARB_PERF_EN adds broadcast / conflict performance counters.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_WIDTH  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_FREE   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
`ifdef CDB_ARB_PERF_EN
  output logic [31:0]                     perf_bcast_cnt,
  output logic [31:0]                     perf_conflict_cnt,
`endif
  output logic                            cdb_valid,
  output logic [TAG_WIDTH-1:0]            cdb_tag,
  output logic [DATA_WIDTH-1:0]           cdb_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TAG_WIDTH-1:0] FREE_TAG = TAG_WIDTH'(TAG_FREE);
  localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      scan_idx;
  logic [PTR_W-1:0]      sel_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  sel_hit;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [TAG_WIDTH-1:0]  tag_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign tag_arr[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping; reset and flush suppress any grant.
  always_comb begin
    gnt      = '0;
    sel_hit  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    if (rst && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!sel_hit && req_valid[scan_idx]) begin
          sel_hit = 1'b1;
          sel_idx = scan_idx;
        end
      end
    end
    if (sel_hit) begin
      gnt[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    next_ptr = (sel_idx == LAST_IDX) ? '0 : sel_idx + PTR_W'(1);
    sel_tag  = tag_arr[sel_idx];
    sel_data = data_arr[sel_idx];
  end

  // A grant carrying the free tag is consumed but leaves the bus idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= FREE_TAG;
      cdb_data  <= '0;
    end else begin
      if (sel_hit) begin
        rr_ptr <= next_ptr;
      end
      if (sel_hit && (sel_tag != FREE_TAG)) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= sel_tag;
        cdb_data  <= sel_data;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag   <= FREE_TAG;
        cdb_data  <= '0;
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_bcast_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (cdb_valid) begin
        perf_bcast_cnt <= perf_bcast_cnt + 32'd1;
      end
      if (!flush && ($countones(req_valid) > 1)) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter against a queue-free reference model
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]     perf_bcast_cnt;
  logic [31:0]     perf_conflict_cnt;
`endif

  logic [TW-1:0] tg [N];
  logic [DW-1:0] dt [N];

  int tests = 0;
  int fails = 0;

  int            ptr = 0;
  int            last_g = -1;
  logic [N-1:0]  last_gnt = '0;
  logic          exp_valid = 1'b0;
  logic [TW-1:0] exp_tag = '0;
  logic [DW-1:0] exp_data = '0;
  logic [31:0]   exp_bc = '0;
  logic [31:0]   exp_cf = '0;
  logic [N-1:0]  pend = '0;

  cdb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .TAG_FREE(0)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .req_valid(req_valid),
    .req_tag(req_tag),
    .req_data(req_data),
    .gnt(gnt),
`ifdef CDB_ARB_PERF_EN
    .perf_bcast_cnt(perf_bcast_cnt),
    .perf_conflict_cnt(perf_conflict_cnt),
`endif
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_tag  = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tg[i];
      req_data[i*DW +: DW] = dt[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Winner is the valid requester with the smallest forward distance from the pointer.
  function automatic int pick();
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && (((i - ptr + N) % N) < bestd)) begin
        bestd = (i - ptr + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic tick();
    int g;
    logic nv;
    logic [TW-1:0] nt;
    logic [DW-1:0] nd;
    #1;
    g = (!rst || flush) ? -1 : pick();
    last_gnt = gnt;
    chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
    last_g = g;
    nv = 1'b0;
    nt = '0;
    nd = '0;
    if (!rst) begin
      ptr = 0;
      exp_bc = '0;
      exp_cf = '0;
    end else begin
      if (exp_valid) exp_bc = exp_bc + 32'd1;
      if (!flush && ($countones(req_valid) >= 2)) exp_cf = exp_cf + 32'd1;
      if (g >= 0) begin
        ptr = (g + 1) % N;
        if (tg[g] != '0) begin
          nv = 1'b1;
          nt = tg[g];
          nd = dt[g];
        end
      end
    end
    @(posedge clk);
    #1;
    exp_valid = nv;
    exp_tag   = nt;
    exp_data  = nd;
    chk("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
    chk("cdb_tag", 32'(cdb_tag), 32'(exp_tag));
    chk("cdb_data", cdb_data, exp_data);
`ifdef CDB_ARB_PERF_EN
    chk("perf_bcast", perf_bcast_cnt, exp_bc);
    chk("perf_conflict", perf_conflict_cnt, exp_cf);
`endif
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tg[i] = TW'(i + 1);
      dt[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset held two cycles, then idle for five.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_valid", 32'(cdb_valid), 32'd0);
      chk("idle_tag", 32'(cdb_tag), 32'd0);
    end

    // Single request from requester 1.
    tg[1] = 3'd3;
    dt[1] = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    tick();
    chk("single_gnt", 32'(last_gnt), 32'h2);
    chk("single_tag", 32'(cdb_tag), 32'd3);
    chk("single_data", cdb_data, 32'hDEAD_BEEF);
    req_valid = 4'b0000;
    tick();
    chk("single_hold1", 32'(cdb_valid), 32'd0);

    // Fairness with all four valid from pointer 0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      tg[i] = TW'(i + 1);
      dt[i] = 32'h1000 * 32'(i + 1);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("fair_gnt", 32'(last_gnt), 32'd1 << (c % 4));
      chk("fair_tag", 32'(cdb_tag), 32'((c % 4) + 1));
    end

    // Wrap: move pointer to 3, then grants 3 then 0 leave the pointer at 1.
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1001;
    tick();
    chk("wrap_gnt3", 32'(last_gnt), 32'h8);
    req_valid = 4'b0001;
    tick();
    chk("wrap_gnt0", 32'(last_gnt), 32'h1);
    req_valid = 4'b1111;
    tick();
    chk("wrap_ptr1", 32'(last_gnt), 32'h2);

    // Flush suppresses the grant; the still-valid requester wins afterwards.
    req_valid = 4'b0100;
    flush = 1'b1;
    tick();
    chk("flush_gnt", 32'(last_gnt), 32'h0);
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    chk("flush_tag", 32'(cdb_tag), 32'd0);
    flush = 1'b0;
    tick();
    chk("post_flush_gnt", 32'(last_gnt), 32'h4);

    // Free-tag request is consumed without a broadcast.
    tg[0] = '0;
    req_valid = 4'b0001;
    tick();
    chk("free_gnt", 32'(last_gnt), 32'h1);
    chk("free_valid", 32'(cdb_valid), 32'd0);
    tg[0] = 3'd1;

    // Reset while a broadcast is on the bus.
    req_valid = 4'b1111;
    tick();
    chk("pre_rst_valid", 32'(cdb_valid), 32'd1);
    rst = 1'b0;
    tick();
    chk("rst_valid", 32'(cdb_valid), 32'd0);
`ifdef CDB_ARB_PERF_EN
    chk("rst_perf_b", perf_bcast_cnt, 32'd0);
    chk("rst_perf_c", perf_conflict_cnt, 32'd0);
`endif
    rst = 1'b1;
    tick();
    chk("rst_ptr0", 32'(last_gnt), 32'h1);

    // Randomized requesters that hold results until granted.
    req_valid = '0;
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          tg[i] = ($urandom_range(0, 9) == 0) ? '0 : TW'($urandom_range(1, 7));
          dt[i] = $urandom;
        end
      end
      req_valid = pend;
      flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 79) != 0);
      tick();
      if (last_g >= 0) pend[last_g] = 1'b0;
      if (flush || !rst) pend = '0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
